// File: rtl/mem_seq.sv
// Memory sequencer/arbiter: grants fetch, load/store and stack requests and walks the memory strobes
// through IDLE/S1/S2/RESP. Define MEM_SEQ_RR_EN for round-robin arbitration (fixed stk>data>fetch otherwise).
module mem_seq #(
   parameter int STACK_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       fetchReq,
   input  logic [3:0] fetchAddr,
   output logic       fetchAck,
   output logic [3:0] opcode,
   output logic [3:0] operand,
   input  logic       dataReq,
   input  logic       dataWr,
   input  logic [3:0] dataAddr,
   input  logic [3:0] dataWdata,
   output logic       dataAck,
   output logic [3:0] dataRdata,
   input  logic       stkReq,
   input  logic       stkPush,
   input  logic [3:0] stkWdata,
   output logic       stkAck,
   output logic [3:0] stkRdata,
   output logic       stkErr,
   output logic       busy,
   output logic       Laddr,
   output logic       Eram,
   output logic       WE,
   output logic       Edata,
   output logic       Esp,
   output logic [1:0] spOp,
   output logic [3:0] addrIn,
   output logic [3:0] ramIn,
   input  logic [3:0] opcodeOut,
   input  logic [3:0] dataOut
);

   typedef enum logic [1:0] {IDLE = 2'd0, S1 = 2'd1, S2 = 2'd2, RESP = 2'd3} state_t;
   typedef enum logic [1:0] {SRC_FETCH = 2'd0, SRC_DATA = 2'd1, SRC_STK = 2'd2} src_t;

   localparam logic [3:0] DEPTH_MAX = 4'(STACK_DEPTH);

   state_t     state_q, state_d;
   src_t       src_q, src_d;
   logic       wr_q, wr_d;
   logic       err_q, err_d;
   logic [3:0] addr_q, addr_d;
   logic [3:0] wdata_q, wdata_d;
   logic [3:0] depth_q, depth_d;
   logic [3:0] opcode_q, opcode_d;
   logic [3:0] operand_q, operand_d;
   logic [3:0] data_rdata_q, data_rdata_d;
   logic [3:0] stk_rdata_q, stk_rdata_d;

   logic [2:0] req_vec;
   logic [2:0] pick;
   logic       gnt_vld;
   src_t       gnt_src;
   logic       stk_err;

   // Returns {valid, source} for the first requesting source in the order p0, p1, p2.
   function automatic logic [2:0] pick3(input logic [2:0] req, input src_t p0, input src_t p1,
                                        input src_t p2);
      logic [2:0] res;
      if (req[p0]) begin
         res = {1'b1, p0};
      end else if (req[p1]) begin
         res = {1'b1, p1};
      end else if (req[p2]) begin
         res = {1'b1, p2};
      end else begin
         res = {1'b0, SRC_FETCH};
      end
      return res;
   endfunction

   assign req_vec = {stkReq, dataReq, fetchReq};
   assign stk_err = stkPush ? (depth_q == DEPTH_MAX) : (depth_q == 4'd0);

`ifdef MEM_SEQ_RR_EN
   src_t last_q, last_d;

   // Rotating priority: the last granted source drops to the bottom.
   always_comb begin
      case (last_q)
         SRC_STK:  pick = pick3(req_vec, SRC_DATA, SRC_FETCH, SRC_STK);
         SRC_DATA: pick = pick3(req_vec, SRC_FETCH, SRC_STK, SRC_DATA);
         default:  pick = pick3(req_vec, SRC_STK, SRC_DATA, SRC_FETCH);
      endcase
   end

   // Grant history register.
   always_comb begin
      last_d = last_q;
      if ((state_q == IDLE) && gnt_vld) begin
         last_d = gnt_src;
      end else begin
         last_d = last_q;
      end
   end

   // Grant history flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= SRC_FETCH;
      end else begin
         last_q <= last_d;
      end
   end
`else
   // Fixed priority arbitration.
   always_comb begin
      pick = pick3(req_vec, SRC_STK, SRC_DATA, SRC_FETCH);
   end
`endif

   assign gnt_vld = pick[2];
   assign gnt_src = src_t'(pick[1:0]);

   // Next state, request latching, read-data capture and depth tracking.
   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      wr_d         = wr_q;
      err_d        = err_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      depth_d      = depth_q;
      opcode_d     = opcode_q;
      operand_d    = operand_q;
      data_rdata_d = data_rdata_q;
      stk_rdata_d  = stk_rdata_q;
      case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               src_d = gnt_src;
               case (gnt_src)
                  SRC_FETCH: begin
                     addr_d  = fetchAddr;
                     wr_d    = 1'b0;
                     wdata_d = 4'd0;
                     err_d   = 1'b0;
                  end
                  SRC_DATA: begin
                     addr_d  = dataAddr;
                     wr_d    = dataWr;
                     wdata_d = dataWdata;
                     err_d   = 1'b0;
                  end
                  default: begin
                     addr_d  = 4'd0;
                     wr_d    = stkPush;
                     wdata_d = stkWdata;
                     err_d   = stk_err;
                  end
               endcase
               // An illegal stack access skips the memory cycles entirely.
               state_d = ((gnt_src == SRC_STK) && stk_err) ? RESP : S1;
            end else begin
               state_d = IDLE;
            end
         end
         S1: state_d = S2;
         S2: begin
            state_d = RESP;
            case (src_q)
               SRC_FETCH: begin
                  opcode_d  = opcodeOut;
                  operand_d = dataOut;
               end
               SRC_DATA: begin
                  if (!wr_q) begin
                     data_rdata_d = dataOut;
                  end else begin
                     data_rdata_d = data_rdata_q;
                  end
               end
               default: begin
                  if (wr_q) begin
                     depth_d = depth_q + 4'd1;
                  end else begin
                     stk_rdata_d = dataOut;
                  end
               end
            endcase
         end
         RESP: begin
            state_d = IDLE;
            if ((src_q == SRC_STK) && !wr_q && !err_q) begin
               depth_d = depth_q - 4'd1;
            end else begin
               depth_d = depth_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Moore decode of strobes and acks from the registered state and latched fields.
   always_comb begin
      Laddr    = 1'b0;
      Eram     = 1'b0;
      WE       = 1'b0;
      Edata    = 1'b0;
      Esp      = 1'b0;
      spOp     = 2'b00;
      addrIn   = 4'd0;
      ramIn    = 4'd0;
      fetchAck = 1'b0;
      dataAck  = 1'b0;
      stkAck   = 1'b0;
      stkErr   = 1'b0;
      case (state_q)
         S1: begin
            if (src_q == SRC_STK) begin
               Esp  = wr_q;
               spOp = wr_q ? 2'b10 : 2'b01;
            end else begin
               Laddr  = 1'b1;
               addrIn = addr_q;
            end
         end
         S2: begin
            case (src_q)
               SRC_FETCH: Eram = 1'b1;
               SRC_DATA: begin
                  if (wr_q) begin
                     WE    = 1'b1;
                     ramIn = wdata_q;
                  end else begin
                     Eram  = 1'b1;
                     Edata = 1'b1;
                  end
               end
               default: begin
                  spOp = 2'b01;
                  if (wr_q) begin
                     WE    = 1'b1;
                     ramIn = wdata_q;
                  end else begin
                     Eram  = 1'b1;
                     Edata = 1'b1;
                  end
               end
            endcase
         end
         RESP: begin
            case (src_q)
               SRC_FETCH: fetchAck = 1'b1;
               SRC_DATA:  dataAck  = 1'b1;
               default: begin
                  stkAck = 1'b1;
                  stkErr = err_q;
                  if (!wr_q && !err_q) begin
                     Esp  = 1'b1;
                     spOp = 2'b11;
                  end else begin
                     Esp  = 1'b0;
                  end
               end
            endcase
         end
         default: begin
            Laddr = 1'b0;
         end
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign opcode    = opcode_q;
   assign operand   = operand_q;
   assign dataRdata = data_rdata_q;
   assign stkRdata  = stk_rdata_q;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         src_q        <= SRC_FETCH;
         wr_q         <= 1'b0;
         err_q        <= 1'b0;
         addr_q       <= 4'd0;
         wdata_q      <= 4'd0;
         depth_q      <= 4'd0;
         opcode_q     <= 4'd0;
         operand_q    <= 4'd0;
         data_rdata_q <= 4'd0;
         stk_rdata_q  <= 4'd0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         wr_q         <= wr_d;
         err_q        <= err_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         depth_q      <= depth_d;
         opcode_q     <= opcode_d;
         operand_q    <= operand_d;
         data_rdata_q <= data_rdata_d;
         stk_rdata_q  <= stk_rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_seq.sv
// Self-checking bench for mem_seq (STACK_DEPTH=2): table of transactions with per-cycle strobe
// expectations against a scoreboard queue, plus async-reset and arbitration sequences.
module tb_mem_seq;

   localparam logic [1:0] K_FETCH = 2'd0;
   localparam logic [1:0] K_DATA  = 2'd1;
   localparam logic [1:0] K_STK   = 2'd2;

   // strobe vector {Laddr, Eram, WE, Edata, Esp, spOp}
   localparam logic [6:0] ST_0    = 7'b0000000;
   localparam logic [6:0] ST_L    = 7'b1000000;
   localparam logic [6:0] ST_E    = 7'b0100000;
   localparam logic [6:0] ST_ED   = 7'b0101000;
   localparam logic [6:0] ST_W    = 7'b0010000;
   localparam logic [6:0] ST_PS1  = 7'b0000110;
   localparam logic [6:0] ST_PS2  = 7'b0010001;
   localparam logic [6:0] ST_PP1  = 7'b0000001;
   localparam logic [6:0] ST_PP2  = 7'b0101001;
   localparam logic [6:0] ST_PP3  = 7'b0000111;

   typedef struct {
      logic [1:0]      kind;
      logic            wr;
      logic [3:0]      addr;
      logic [3:0]      wdata;
      logic [7:0]      exp_rd;
      logic            exp_err;
      int              exp_lat;
      logic [0:2][6:0] exp_st;
      logic [3:0]      exp_addr;
      logic [3:0]      exp_ram;
   } vec_t;

   logic clk, rst_n;
   logic fetchReq, dataReq, dataWr, stkReq, stkPush;
   logic [3:0] fetchAddr, dataAddr, dataWdata, stkWdata;
   logic fetchAck, dataAck, stkAck, stkErr, busy;
   logic [3:0] opcode, operand, dataRdata, stkRdata;
   logic Laddr, Eram, WE, Edata, Esp;
   logic [1:0] spOp;
   logic [3:0] addrIn, ramIn, opcodeOut, dataOut;

   logic [3:0] opmem [16];
   logic [3:0] datamem [16];
   logic [3:0] sp, mem_addr;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t sb[$];
   vec_t tbl[13];

   mem_seq #(.STACK_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchAck(fetchAck),
      .opcode(opcode), .operand(operand),
      .dataReq(dataReq), .dataWr(dataWr), .dataAddr(dataAddr), .dataWdata(dataWdata),
      .dataAck(dataAck), .dataRdata(dataRdata),
      .stkReq(stkReq), .stkPush(stkPush), .stkWdata(stkWdata),
      .stkAck(stkAck), .stkRdata(stkRdata), .stkErr(stkErr), .busy(busy),
      .Laddr(Laddr), .Eram(Eram), .WE(WE), .Edata(Edata), .Esp(Esp), .spOp(spOp),
      .addrIn(addrIn), .ramIn(ramIn), .opcodeOut(opcodeOut), .dataOut(dataOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural memory with address latch and stack pointer
   always @(posedge clk) begin
      if (Laddr) mem_addr <= addrIn;
      if (WE) datamem[(spOp == 2'b01) ? sp : mem_addr] <= ramIn;
      if (Esp && spOp == 2'b10) sp <= sp - 4'd1;
      if (Esp && spOp == 2'b11) sp <= sp + 4'd1;
   end
   assign opcodeOut = opmem[mem_addr];
   assign dataOut   = (spOp == 2'b01) ? datamem[sp] : datamem[mem_addr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] k, input logic wr, input logic [3:0] a,
                               input logic [3:0] wd, input logic [7:0] rd, input logic e,
                               input int lat, input logic [6:0] s1, input logic [6:0] s2,
                               input logic [6:0] s3, input logic [3:0] ea, input logic [3:0] er);
      vec_t v;
      v.kind = k; v.wr = wr; v.addr = a; v.wdata = wd; v.exp_rd = rd; v.exp_err = e;
      v.exp_lat = lat; v.exp_st = {s1, s2, s3}; v.exp_addr = ea; v.exp_ram = er;
      return v;
   endfunction

   task automatic do_txn(input string name, input vec_t v);
      vec_t exp;
      logic got, ack;
      int lat;
      logic [7:0] rd;
      got = 1'b0;
      lat = 0;
      @(negedge clk);
      sb.push_back(v);
      case (v.kind)
         K_FETCH: begin fetchReq = 1'b1; fetchAddr = v.addr; end
         K_DATA:  begin dataReq = 1'b1; dataWr = v.wr; dataAddr = v.addr; dataWdata = v.wdata; end
         default: begin stkReq = 1'b1; stkPush = v.wr; stkWdata = v.wdata; end
      endcase
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(negedge clk);
         if (cyc <= v.exp_lat)
            check($sformatf("%s_strobe_c%0d", name, cyc), 64'({Laddr, Eram, WE, Edata, Esp, spOp}),
                  64'(v.exp_st[cyc-1]));
         if (cyc == 1) check($sformatf("%s_addrIn", name), 64'(addrIn), 64'(v.exp_addr));
         if (cyc == 2 && v.exp_lat >= 2) check($sformatf("%s_ramIn", name), 64'(ramIn), 64'(v.exp_ram));
         ack = (v.kind == K_FETCH) ? fetchAck : (v.kind == K_DATA) ? dataAck : stkAck;
         if (ack) begin
            got = 1'b1;
            lat = cyc;
            break;
         end
      end
      fetchReq = 1'b0; dataReq = 1'b0; stkReq = 1'b0;
      if (!got) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_timeout: got no ack, expected ack", name);
         void'(sb.pop_front());
      end else begin
         exp = sb.pop_front();
         case (exp.kind)
            K_FETCH: rd = {opcode, operand};
            K_DATA:  rd = {4'h0, dataRdata};
            default: rd = {4'h0, stkRdata};
         endcase
         check($sformatf("%s_latency", name), 64'(lat), 64'(exp.exp_lat));
         check($sformatf("%s_rdata", name), 64'(rd), 64'(exp.exp_rd));
         check($sformatf("%s_stkErr", name), 64'(stkErr), 64'(exp.exp_err));
      end
   endtask

   initial begin
      logic [1:0] arb_q[$];
      logic [1:0] exp_src, act_src;
      int acks, got;
      vec_t v;

      for (int i = 0; i < 16; i++) begin
         opmem[i]   = 4'(i);
         datamem[i] = 4'(15 - i);
      end
      opmem[3] = 4'hA; datamem[3] = 4'h5;
      sp = 4'hF; mem_addr = 4'h0;
      rst_n = 1'b0;
      fetchReq = 1'b0; dataReq = 1'b0; stkReq = 1'b0;
      dataWr = 1'b0; stkPush = 1'b0;
      fetchAddr = 4'h0; dataAddr = 4'h0; dataWdata = 4'h0; stkWdata = 4'h0;

      tbl[0]  = mk(K_FETCH, 1'b0, 4'h3, 4'h0, 8'hA5, 1'b0, 3, ST_L, ST_E, ST_0, 4'h3, 4'h0);
      tbl[1]  = mk(K_DATA,  1'b1, 4'h2, 4'h7, 8'h00, 1'b0, 3, ST_L, ST_W, ST_0, 4'h2, 4'h7);
      tbl[2]  = mk(K_DATA,  1'b0, 4'h2, 4'h0, 8'h07, 1'b0, 3, ST_L, ST_ED, ST_0, 4'h2, 4'h0);
      tbl[3]  = mk(K_STK,   1'b1, 4'h0, 4'hF, 8'h00, 1'b0, 3, ST_PS1, ST_PS2, ST_0, 4'h0, 4'hF);
      tbl[4]  = mk(K_STK,   1'b1, 4'h0, 4'hE, 8'h00, 1'b0, 3, ST_PS1, ST_PS2, ST_0, 4'h0, 4'hE);
      tbl[5]  = mk(K_STK,   1'b1, 4'h0, 4'h3, 8'h00, 1'b1, 1, ST_0, ST_0, ST_0, 4'h0, 4'h0);
      tbl[6]  = mk(K_STK,   1'b0, 4'h0, 4'h0, 8'h0E, 1'b0, 3, ST_PP1, ST_PP2, ST_PP3, 4'h0, 4'h0);
      tbl[7]  = mk(K_STK,   1'b0, 4'h0, 4'h0, 8'h0F, 1'b0, 3, ST_PP1, ST_PP2, ST_PP3, 4'h0, 4'h0);
      tbl[8]  = mk(K_STK,   1'b0, 4'h0, 4'h0, 8'h0F, 1'b1, 1, ST_0, ST_0, ST_0, 4'h0, 4'h0);
      tbl[9]  = mk(K_FETCH, 1'b0, 4'h5, 4'h0, 8'h5A, 1'b0, 3, ST_L, ST_E, ST_0, 4'h5, 4'h0);
      tbl[10] = mk(K_DATA,  1'b0, 4'h9, 4'h0, 8'h06, 1'b0, 3, ST_L, ST_ED, ST_0, 4'h9, 4'h0);
      tbl[11] = mk(K_DATA,  1'b1, 4'h9, 4'h1, 8'h06, 1'b0, 3, ST_L, ST_W, ST_0, 4'h9, 4'h1);
      tbl[12] = mk(K_DATA,  1'b0, 4'h9, 4'h0, 8'h01, 1'b0, 3, ST_L, ST_ED, ST_0, 4'h9, 4'h0);

      repeat (2) @(negedge clk);
      check("reset_outputs",
            64'({fetchAck, dataAck, stkAck, stkErr, busy, Laddr, Eram, WE, Edata, Esp, spOp,
                 addrIn, ramIn, opcode, operand, dataRdata, stkRdata}), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) do_txn($sformatf("v%0d", i), tbl[i]);

      // Async reset during S2 of a store after one push
      do_txn("rst_push", mk(K_STK, 1'b1, 4'h0, 4'h9, 8'h0F, 1'b0, 3, ST_PS1, ST_PS2, ST_0, 4'h0, 4'h9));
      @(negedge clk);
      dataReq = 1'b1; dataWr = 1'b1; dataAddr = 4'h4; dataWdata = 4'h3;
      @(negedge clk);
      check("rst_s1_laddr", 64'(Laddr), 64'd1);
      @(negedge clk);
      check("rst_s2_we", 64'(WE), 64'd1);
      #1 rst_n = 1'b0;
      #1 check("rst_async_drop", 64'({WE, Laddr, busy, dataAck}), 64'd0);
      dataReq = 1'b0; dataWr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      acks = 0;
      repeat (4) begin
         @(negedge clk);
         if (dataAck) acks++;
      end
      check("rst_no_ack", 64'(acks), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      do_txn("rst_pop_depth0", mk(K_STK, 1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1, ST_0, ST_0, ST_0, 4'h0, 4'h0));

      // Arbitration with all three sources held high
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
`ifdef MEM_SEQ_RR_EN
      arb_q = '{K_STK, K_DATA, K_FETCH, K_STK};
`else
      arb_q = '{K_STK, K_STK, K_STK, K_STK};
`endif
      fetchReq = 1'b1; fetchAddr = 4'h0;
      dataReq = 1'b1; dataWr = 1'b0; dataAddr = 4'h0;
      stkReq = 1'b1; stkPush = 1'b0;
      got = 0;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
         @(negedge clk);
         if (fetchAck || dataAck || stkAck) begin
            act_src = stkAck ? K_STK : (dataAck ? K_DATA : K_FETCH);
            exp_src = arb_q.pop_front();
            check($sformatf("arb_grant%0d", got), 64'(act_src), 64'(exp_src));
            got++;
         end
      end
      fetchReq = 1'b0; dataReq = 1'b0; stkReq = 1'b0;
      if (got < 4) begin
         n_cmp++; n_bad++;
         $display("FAIL arb_timeout: got %0d grants, expected 4", got);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_seq.md
# mem_seq

Memory sequencer and arbiter sitting between the CPU control unit and the `memory` block. It accepts requests from three sources: instruction fetch, data load/store, and stack push/pop. It grants one request at a time and drives the memory control strobes (Laddr, Eram, WE, Edata, Esp, spOp) through a fixed multi-cycle sequence. It returns read data with a one-cycle acknowledge, and tracks stack depth so overflow and underflow never reach the memory.

## Interface
- STACK_DEPTH, 4, maximum number of stacked words, range 1–15.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetchReq  in  1  fetch request, held until fetchAck.
- fetchAddr  in  4  fetch address.
- fetchAck  out  1  one-cycle pulse; opcode and operand are valid while it is high.
- opcode  out  4  captured opcodeOut.
- operand  out  4  captured dataOut.
- dataReq  in  1  load/store request, held until dataAck.
- dataWr  in  1  1 = store, 0 = load.
- dataAddr  in  4  load/store address.
- dataWdata  in  4  store data.
- dataAck  out  1  one-cycle completion pulse.
- dataRdata  out  4  load result, valid during dataAck.
- stkReq  in  1  stack request, held until stkAck.
- stkPush  in  1  1 = push, 0 = pop.
- stkWdata  in  4  push data.
- stkAck  out  1  one-cycle completion pulse.
- stkRdata  out  4  pop result, valid during stkAck.
- stkErr  out  1  high together with stkAck on overflow or underflow.
- busy  out  1  high in every state except IDLE.
- Laddr, Eram, WE, Edata, Esp  out  1 each  memory strobes.
- spOp  out  2  stack pointer operation.
  - With Esp=1: 10 = decrement SP, 11 = increment SP.
  - With Esp=0: 01 routes SP to the memory address.
- addrIn  out  4  memory address; 0 when Laddr=0.
- ramIn  out  4  memory write data; 0 when WE=0.
- opcodeOut, dataOut  in  4 each  memory read outputs.

## Operation
- States: IDLE, S1, S2, RESP.
- IDLE: arbitrate among the pending requests.
  - The winner's fields are latched into internal registers. Later changes or deasserts of the request do not affect the operation in flight.
  - The next state is S1, or RESP on a stack error.
- Per-state strobes. Any strobe not listed is 0.
  - Fetch: S1 Laddr=1, addrIn=fetchAddr. S2 Eram=1, Edata=0. Capture opcodeOut and dataOut at the end of S2.
  - Load: S1 Laddr=1, addrIn=dataAddr. S2 Eram=1, Edata=1. Capture dataOut into dataRdata at the end of S2.
  - Store: S1 Laddr=1, addrIn=dataAddr. S2 WE=1, ramIn=dataWdata.
  - Push: S1 Esp=1, spOp=10. S2 Esp=0, spOp=01, WE=1, ramIn=stkWdata. depth increments at the end of S2.
  - Pop: S1 Esp=0, spOp=01. S2 spOp=01, Eram=1, Edata=1; capture dataOut into stkRdata. RESP Esp=1, spOp=11. depth decrements at the end of RESP.
- depth is an internal counter, 0..STACK_DEPTH.
- Stack error: a push when depth==STACK_DEPTH, or a pop when depth==0.
  - The request is granted and the FSM goes directly from IDLE to RESP.
  - No strobes are asserted and depth is unchanged.
  - stkAck=1 and stkErr=1; stkRdata holds its previous value.
- RESP: pulse the ack of the granted source (plus the pop SP increment). The next state is always IDLE.
- Reset state for all outputs:
  - All strobes, acks, stkErr and busy are 0.
  - spOp, addrIn and ramIn are 0.
  - opcode, operand, dataRdata and stkRdata are 0.
  - depth is 0 and the FSM is in IDLE.

## Timing
- A request sampled in IDLE at edge e0 is serviced in S1 (e0–e1) and S2 (e1–e2). The ack is high for e2–e3, and the FSM is back in IDLE after e3.
- Latency is 3 cycles from acceptance to ack. A stack error acks after 1 cycle.
- Throughput is 1 transaction per 4 cycles (2 for a stack error). The FSM spends at least one cycle in IDLE between transactions.
- Strobes and addrIn/ramIn are decoded from the registered state and latched fields: Moore outputs, glitch-free per cycle.
- Read data registers update only on capture. They hold their value afterwards.
- Async reset mid-operation aborts immediately.
  - WE and Laddr drop without waiting for a clock, and no ack is issued.
  - depth returns to 0, even though the memory SP is not restored. Software must reset both together.
- A request still high in the cycle after its ack is treated as a new request.

## Configuration
- MEM_SEQ_RR_EN defined: round-robin arbitration.
  - The last-granted source becomes lowest priority.
  - After reset the order is stk > data > fetch.
  - A stack-error grant also rotates the priority.
- MEM_SEQ_RR_EN undefined: fixed priority stk > data > fetch. Fetch can starve under sustained stack or data traffic.

## Test plan
- Fetch of address 4'h3 where memory holds {opcode 4'hA, data 4'h5}: fetchAck appears 3 cycles after acceptance with opcode=A and operand=5; Laddr is high only in S1 and Eram only in S2.
- Store 4'h7 to address 4'h2, then load address 4'h2: WE=1 with ramIn=7 for exactly one cycle; dataRdata=7 on dataAck.
- Push 4'hF, push 4'hE, pop, pop: stkRdata returns E then F; spOp sequence 10, 01 per push and 01, 01, 11 per pop; depth ends at 0.
- STACK_DEPTH=2: a third push gives stkAck and stkErr 1 cycle after acceptance with no WE. A pop at depth 0 gives stkErr=1 with stkRdata unchanged.
- fetchReq, dataReq and stkReq all held high: without the macro the grant order is stk, stk, … with no fetch. With MEM_SEQ_RR_EN the grant order is stk, data, fetch, stk.
- Assert rst_n=0 during S2 of a store: WE drops asynchronously, no dataAck is issued, and busy=0 and depth=0 after reset release.
